// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio frame sequencer.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_PROCESS = 2'd2,
        ST_DRAIN   = 2'd3
    } seq_state_t;

    localparam logic CFG_SPM = 1'b0;
    localparam logic CFG_SFC = 1'b1;

    function automatic int chunks(input int samples, input int size, input int input_size);
        return samples * size / input_size;
    endfunction

endpackage

// File: rtl/audio_frame_sequencer_counter.sv
// Chunk index counter: clear has priority over increment; last flags the final chunk.
module chunk_counter #(
    parameter int IDX_W = 6,
    parameter int LAST  = (1 << IDX_W) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [IDX_W-1:0] cnt,
    output logic             last
);

    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == IDX_W'(LAST));

endmodule

// File: rtl/audio_frame_sequencer.sv
// Fill / process / drain sequencing of one audio frame through the FFT core,
// with config writes held off while a transform is running.
module audio_frame_sequencer
    import audio_pkg::*;
#(
    parameter  int INPUT_SIZE = 512,
    parameter  int SAMPLES    = 2048,
    parameter  int SIZE       = 16,
    localparam int CHUNKS     = chunks(SAMPLES, SIZE, INPUT_SIZE),
    localparam int IDX_W      = $clog2(CHUNKS),
    localparam int CI_W       = $clog2(SAMPLES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  lde_valid,
    input  logic [INPUT_SIZE-1:0] lde_data,
    output logic                  lde_ready,
    input  logic                  ste_req,
    output logic                  ste_valid,
    output logic [INPUT_SIZE-1:0] ste_data,
    input  logic                  cfg_valid,
    input  logic                  cfg_sel,
    input  logic [CI_W-1:0]       cfg_index,
    input  logic [15:0]           cfg_data,
    output logic                  cfg_ready,
    output logic                  ap_data_wr_en,
    output logic [IDX_W-1:0]      ap_input_index,
    output logic [INPUT_SIZE-1:0] ap_data_in,
    output logic                  ap_pitch_shift_wr_en,
    output logic [4:0]            ap_pitch_shift_semitones,
    output logic                  ap_freq_coeff_wr_en,
    output logic [CI_W-1:0]       ap_freq_coeff_index,
    output logic [15:0]           ap_freq_coeff_in,
    output logic [IDX_W-1:0]      ap_output_index,
    input  logic [INPUT_SIZE-1:0] ap_data_out,
    output logic                  ap_start,
    input  logic                  ap_done,
    output logic [1:0]            state_o
);

    if (INPUT_SIZE % SIZE != 0) begin : g_bad_size
        $error("INPUT_SIZE must be a whole number of samples");
    end

    seq_state_t state_q, state_d;

    logic             lde_acc, ste_acc, cfg_acc;
    logic             fill_clr, drain_clr, fill_last, drain_last;
    logic [IDX_W-1:0] fill_cnt, drain_cnt;

    logic                  wr_en_q, start_pend_q, start_q, ste_valid_q;
    logic [IDX_W-1:0]      in_idx_q, out_idx_q;
    logic [INPUT_SIZE-1:0] din_q;
    logic                  ps_wr_q, fc_wr_q;
    logic [4:0]            semi_q;
    logic [CI_W-1:0]       fc_idx_q;
    logic [15:0]           fc_data_q;

    always_comb begin
        state_d   = state_q;
        lde_ready = (state_q == ST_IDLE) || (state_q == ST_FILL);
        cfg_ready = (state_q != ST_PROCESS);
        lde_acc   = lde_valid && lde_ready && !flush;
        cfg_acc   = cfg_valid && cfg_ready && !flush;
        ste_acc   = ste_req && (state_q == ST_DRAIN) && !flush;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:    if (lde_acc) state_d = ST_FILL;
                ST_FILL:    if (lde_acc && fill_last) state_d = ST_PROCESS;
                ST_PROCESS: if (ap_done) state_d = ST_DRAIN;
                ST_DRAIN:   if (ste_acc && drain_last) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Fill counter also clears on the last beat so it never wraps into the next frame.
    assign fill_clr  = flush || (lde_acc && fill_last);
    assign drain_clr = flush || (ste_acc && drain_last);

    chunk_counter #(.IDX_W(IDX_W), .LAST(CHUNKS - 1)) u_fill_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (lde_acc),
        .clr  (fill_clr),
        .cnt  (fill_cnt),
        .last (fill_last)
    );

    chunk_counter #(.IDX_W(IDX_W), .LAST(CHUNKS - 1)) u_drain_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (ste_acc),
        .clr  (drain_clr),
        .cnt  (drain_cnt),
        .last (drain_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_en_q      <= 1'b0;
            in_idx_q     <= '0;
            din_q        <= '0;
            start_pend_q <= 1'b0;
            start_q      <= 1'b0;
            ste_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            ps_wr_q      <= 1'b0;
            semi_q       <= '0;
            fc_wr_q      <= 1'b0;
            fc_idx_q     <= '0;
            fc_data_q    <= '0;
        end else begin
            state_q <= state_d;
            wr_en_q <= lde_acc;
            if (lde_acc) begin
                in_idx_q <= fill_cnt;
                din_q    <= lde_data;
            end
            // Start lags the last write by one cycle; a flush in between cancels it.
            start_pend_q <= lde_acc && fill_last;
            start_q      <= start_pend_q && !flush;
            ste_valid_q  <= ste_acc;
            if (ste_acc) out_idx_q <= drain_cnt;
            ps_wr_q <= cfg_acc && (cfg_sel == CFG_SPM);
            fc_wr_q <= cfg_acc && (cfg_sel == CFG_SFC);
            if (cfg_acc && cfg_sel == CFG_SPM) semi_q <= cfg_data[4:0];
            if (cfg_acc && cfg_sel == CFG_SFC) begin
                fc_idx_q  <= cfg_index;
                fc_data_q <= cfg_data;
            end
        end
    end

    assign ap_data_wr_en            = wr_en_q;
    assign ap_input_index           = in_idx_q;
    assign ap_data_in               = din_q;
    assign ap_start                 = start_q;
    assign ap_output_index          = out_idx_q;
    assign ste_valid                = ste_valid_q;
    assign ste_data                 = ste_valid_q ? ap_data_out : '0;
    assign ap_pitch_shift_wr_en     = ps_wr_q;
    assign ap_pitch_shift_semitones = semi_q;
    assign ap_freq_coeff_wr_en      = fc_wr_q;
    assign ap_freq_coeff_index      = fc_idx_q;
    assign ap_freq_coeff_in         = fc_data_q;
    assign state_o                  = state_q;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Directed frame scenarios followed by randomized traffic, checked every cycle against a frame-level model.
module tb_audio_frame_sequencer;

    localparam int W  = 512;
    localparam int CH = 64;
    localparam int IW = 6;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst, flush, lde_valid, ste_req, cfg_valid, cfg_sel, ap_done;
    logic [W-1:0]  lde_data, ste_data, ap_data_in, ap_data_out;
    logic [CW-1:0] cfg_index, ap_freq_coeff_index;
    logic [15:0]   cfg_data, ap_freq_coeff_in;
    logic          lde_ready, ste_valid, cfg_ready, ap_data_wr_en, ap_pitch_shift_wr_en;
    logic          ap_freq_coeff_wr_en, ap_start;
    logic [IW-1:0] ap_input_index, ap_output_index;
    logic [4:0]    ap_pitch_shift_semitones;
    logic [1:0]    state_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    audio_frame_sequencer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lde_valid(lde_valid), .lde_data(lde_data), .lde_ready(lde_ready),
        .ste_req(ste_req), .ste_valid(ste_valid), .ste_data(ste_data),
        .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_index(cfg_index),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .ap_data_wr_en(ap_data_wr_en), .ap_input_index(ap_input_index), .ap_data_in(ap_data_in),
        .ap_pitch_shift_wr_en(ap_pitch_shift_wr_en),
        .ap_pitch_shift_semitones(ap_pitch_shift_semitones),
        .ap_freq_coeff_wr_en(ap_freq_coeff_wr_en), .ap_freq_coeff_index(ap_freq_coeff_index),
        .ap_freq_coeff_in(ap_freq_coeff_in), .ap_output_index(ap_output_index),
        .ap_data_out(ap_data_out), .ap_start(ap_start), .ap_done(ap_done), .state_o(state_o)
    );

    // Stand-in processor: stores chunks, returns their complement.
    logic [W-1:0] pmem [CH];
    initial for (int i = 0; i < CH; i++) pmem[i] = '0;
    always @(posedge clk) if (ap_data_wr_en) pmem[ap_input_index] <= ap_data_in;
    assign ap_data_out = ~pmem[ap_output_index];

    function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endfunction

    // Frame-level model: phase 0 idle, 1 filling, 2 transform, 3 draining.
    int           m_phase, m_n;
    logic [W-1:0] m_beats [CH];
    logic         start_due;
    logic         e_wr, e_start, e_ps, e_fc, e_sv;
    int           e_idx, e_oidx, e_fci;
    logic [W-1:0] e_din, e_sdata;
    logic [4:0]   e_semi;
    logic [15:0]  e_fcd;

    task automatic model_reset();
        m_phase = 0; m_n = 0; start_due = 0;
        e_wr = 0; e_start = 0; e_ps = 0; e_fc = 0; e_sv = 0;
        e_idx = 0; e_oidx = 0; e_fci = 0; e_din = '0; e_sdata = '0; e_semi = '0; e_fcd = '0;
    endtask

    task automatic model_step();
        int ph;
        ph = m_phase;
        e_start = start_due && !flush;
        start_due = 0;
        e_wr = 0; e_ps = 0; e_fc = 0; e_sv = 0; e_sdata = '0;
        if (flush) begin
            m_phase = 0; m_n = 0;
        end else begin
            if (lde_valid && ph <= 1) begin
                e_wr = 1; e_idx = m_n; e_din = lde_data; m_beats[m_n] = lde_data;
                m_phase = 1;
                if (m_n == CH - 1) begin m_phase = 2; m_n = 0; start_due = 1; end
                else m_n++;
            end
            if (cfg_valid && ph != 2) begin
                if (cfg_sel) begin e_fc = 1; e_fci = int'(cfg_index); e_fcd = cfg_data; end
                else begin e_ps = 1; e_semi = cfg_data[4:0]; end
            end
            if (ph == 2 && ap_done) begin m_phase = 3; m_n = 0; end
            if (ph == 3 && ste_req) begin
                e_sv = 1; e_oidx = m_n; e_sdata = ~m_beats[m_n];
                if (m_n == CH - 1) begin m_phase = 0; m_n = 0; end
                else m_n++;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        chk("state", W'(state_o), W'(m_phase));
        chk("lde_ready", W'(lde_ready), W'(m_phase <= 1));
        chk("cfg_ready", W'(cfg_ready), W'(m_phase != 2));
        chk("wr_en", W'(ap_data_wr_en), W'(e_wr));
        if (e_wr) begin
            chk("in_index", W'(ap_input_index), W'(e_idx));
            chk("data_in", ap_data_in, e_din);
        end
        chk("ap_start", W'(ap_start), W'(e_start));
        chk("ps_wr", W'(ap_pitch_shift_wr_en), W'(e_ps));
        if (e_ps) chk("semitones", W'(ap_pitch_shift_semitones), W'(e_semi));
        chk("fc_wr", W'(ap_freq_coeff_wr_en), W'(e_fc));
        if (e_fc) begin
            chk("fc_index", W'(ap_freq_coeff_index), W'(e_fci));
            chk("fc_in", W'(ap_freq_coeff_in), W'(e_fcd));
        end
        chk("ste_valid", W'(ste_valid), W'(e_sv));
        if (e_sv) chk("out_index", W'(ap_output_index), W'(e_oidx));
        chk("ste_data", ste_data, e_sdata);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        rst = 1; flush = 0; lde_valid = 0; lde_data = '0; ste_req = 0; cfg_valid = 0;
        cfg_sel = 0; cfg_index = '0; cfg_data = '0; ap_done = 0;
        repeat (2) @(posedge clk);
        #2 rst = 0;

        // reset values
        chk("rst_state", W'(state_o), W'(0));
        chk("rst_lde_ready", W'(lde_ready), W'(1));
        chk("rst_cfg_ready", W'(cfg_ready), W'(1));
        chk("rst_outs", W'({ap_data_wr_en, ap_start, ste_valid, ap_pitch_shift_wr_en,
                            ap_freq_coeff_wr_en}), W'(0));
        chk("rst_data", ap_data_in | ste_data, W'(0));

        // full frame, back to back, data = index
        for (int i = 0; i < CH; i++) begin
            lde_valid = 1; lde_data = W'(i);
            tick();
            chk("fill_wr", W'(ap_data_wr_en), W'(1));
            chk("fill_idx", W'(ap_input_index), W'(i));
            chk("fill_din", ap_data_in, W'(i));
        end
        lde_valid = 0;
        chk("proc_state", W'(state_o), W'(2));
        chk("proc_lde_ready", W'(lde_ready), W'(0));
        chk("start_early", W'(ap_start), W'(0));
        tick();
        chk("start_pulse", W'(ap_start), W'(1));
        chk("model_start", W'(e_start), W'(1));
        chk("wr_after_last", W'(ap_data_wr_en), W'(0));

        // config held off while transforming
        cfg_valid = 1; cfg_sel = 0; cfg_data = 16'd5;
        chk("cfg_ready_proc", W'(cfg_ready), W'(0));
        tick();
        cfg_valid = 0;
        chk("start_once", W'(ap_start), W'(0));
        chk("ps_blocked", W'(ap_pitch_shift_wr_en), W'(0));

        repeat (100) tick();
        chk("proc_wait", W'(state_o), W'(2));
        ap_done = 1;
        tick();
        ap_done = 0;
        chk("drain_state", W'(state_o), W'(3));
        for (int i = 0; i < CH; i++) begin
            ste_req = 1;
            tick();
            chk("drain_valid", W'(ste_valid), W'(1));
            chk("drain_oidx", W'(ap_output_index), W'(i));
            chk("drain_data", ste_data, ~W'(i));
        end
        ste_req = 0;
        chk("drain_done", W'(state_o), W'(0));

        // coefficient write in IDLE
        cfg_valid = 1; cfg_sel = 1; cfg_index = 11'd2047; cfg_data = 16'h8000;
        tick();
        cfg_valid = 0;
        chk("sfc_wr", W'(ap_freq_coeff_wr_en), W'(1));
        chk("sfc_idx", W'(ap_freq_coeff_index), W'(2047));
        chk("sfc_in", W'(ap_freq_coeff_in), W'(16'h8000));
        chk("sfc_no_ps", W'(ap_pitch_shift_wr_en), W'(0));
        tick();
        chk("sfc_pulse", W'(ap_freq_coeff_wr_en), W'(0));

        // stray requests / done outside their phases
        ste_req = 1;
        tick();
        chk("idle_req", W'(ste_valid), W'(0));
        chk("idle_req_state", W'(state_o), W'(0));
        lde_valid = 1; lde_data = W'(0);
        tick();
        lde_valid = 0; ap_done = 1;
        tick();
        ap_done = 0; ste_req = 0;
        chk("fill_stray_state", W'(state_o), W'(1));
        chk("fill_stray_valid", W'(ste_valid), W'(0));

        // flush alongside the 63rd beat
        for (int i = 1; i < CH - 2; i++) begin
            lde_valid = 1; lde_data = W'(i);
            tick();
        end
        lde_data = W'(CH - 2); flush = 1;
        tick();
        flush = 0; lde_valid = 0;
        chk("flush_nowr", W'(ap_data_wr_en), W'(0));
        chk("flush_state", W'(state_o), W'(0));
        repeat (3) begin
            tick();
            chk("flush_nostart", W'(ap_start), W'(0));
        end
        for (int i = 0; i < CH; i++) begin
            lde_valid = 1; lde_data = rand_beat();
            tick();
            if (i == 0) chk("restart_idx", W'(ap_input_index), W'(0));
        end
        lde_valid = 0;
        repeat (3) tick();
        ap_done = 1;
        tick();
        ap_done = 0;
        for (int i = 0; i < 10; i++) begin
            ste_req = 1;
            tick();
        end

        // async reset while chunk 10 is being requested
        #1 rst = 1;
        #1;
        chk("arst_state", W'(state_o), W'(0));
        chk("arst_outs", W'({ap_data_wr_en, ap_start, ste_valid, ap_pitch_shift_wr_en,
                             ap_freq_coeff_wr_en}), W'(0));
        chk("arst_oidx", W'(ap_output_index), W'(0));
        chk("arst_data", ste_data, W'(0));
        chk("arst_ready", W'({lde_ready, cfg_ready}), W'(2'b11));
        ste_req = 0;
        @(posedge clk);
        #3 rst = 0;
        ap_done = 1;
        tick();
        ap_done = 0;
        chk("idle_done_ignored", W'(state_o), W'(0));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            lde_valid = ($urandom_range(0, 3) != 0);
            lde_data  = rand_beat();
            ste_req   = ($urandom_range(0, 2) != 0);
            ap_done   = ($urandom_range(0, 15) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_sel   = 1'($urandom_range(0, 1));
            cfg_index = CW'($urandom_range(0, 2047));
            cfg_data  = 16'($urandom());
            flush     = ($urandom_range(0, 299) == 0);
            tick();
        end
        lde_valid = 0; ste_req = 0; ap_done = 0; cfg_valid = 0; flush = 0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
